// File: rtl/lc3_mem_if.sv
// LC-3 memory-access stage: MAR/MDR, one req/ack transaction per mio_en rise, ready/acv/bus_err.
// Define LC3_MMIO_EN to map the keyboard/display registers at FE00..FE06 internally.
module lc3_mem_if #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        psr_15,
  output logic [15:0] mdr_out,
  output logic        ready,
  output logic        acv,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
`ifdef LC3_MMIO_EN
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
`endif
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] mar_q, mar_d, mdr_q, mdr_d, cnt_q, cnt_d;
  logic        acv_q, acv_d, we_q, we_d, err_q, err_d, mio_en_q;
  logic        busy, start;
`ifdef LC3_MMIO_EN
  logic        kbsr_q, kbsr_d, disp_valid_q, disp_valid_d;
  logic [7:0]  kbdr_q, kbdr_d, disp_data_q, disp_data_d;
  logic        mmio_hit;
  assign mmio_hit = (mar_q[15:3] == 13'h1FC0) && !mar_q[0];
`endif

  assign busy  = (state_q != IDLE);
  assign start = mio_en & ~mio_en_q & ~busy & ~acv_q;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    acv_d   = acv_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef LC3_MMIO_EN
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
`endif
    if (!busy && ld_mar) begin
      mar_d = bus_in;
      acv_d = psr_15 & ((bus_in < 16'h3000) | (bus_in >= 16'hFE00));
    end
    if (!busy && ld_mdr) mdr_d = bus_in;
    case (state_q)
      IDLE: if (start) begin
        err_d = 1'b0;
        we_d  = r_w;
        cnt_d = '0;
        state_d = REQ;
`ifdef LC3_MMIO_EN
        if (mmio_hit) begin
          // Device registers complete internally; only DDR accepts writes.
          state_d = DONE;
          if (r_w) begin
            if (mar_q[2:1] == 2'd3) begin
              disp_data_d  = mdr_q[7:0];
              disp_valid_d = 1'b1;
            end
          end else begin
            case (mar_q[2:1])
              2'd0: mdr_d = {kbsr_q, 15'h0};
              2'd1: begin mdr_d = {8'h00, kbdr_q}; kbsr_d = 1'b0; end
              2'd2: mdr_d = {disp_ready, 15'h0};
              default: mdr_d = {8'h00, disp_data_q};
            endcase
          end
        end
`endif
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) mdr_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) mdr_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LC3_MMIO_EN
    // A fresh keystroke beats a simultaneous KBDR read clearing the flag.
    if (kb_valid) begin
      kbsr_d = 1'b1;
      kbdr_d = kb_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mar_q    <= '0;
      mdr_q    <= '0;
      cnt_q    <= '0;
      acv_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      mio_en_q <= 1'b0;
`ifdef LC3_MMIO_EN
      kbsr_q       <= 1'b0;
      kbdr_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      cnt_q    <= cnt_d;
      acv_q    <= acv_d;
      we_q     <= we_d;
      err_q    <= err_d;
      mio_en_q <= mio_en;
`ifdef LC3_MMIO_EN
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
`endif
    end
  end

  assign mdr_out   = mdr_q;
  assign acv       = acv_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ready     = (state_q == DONE);
  assign bus_err   = ready & err_q;
`ifdef LC3_MMIO_EN
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
`endif
endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: stimulus pushes expected completions, a monitor checks each ready pulse.
module tb_lc3_mem_if;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] bus_in = '0, mem_rdata = '0;
  logic        ld_mar = 0, ld_mdr = 0, mio_en = 0, r_w = 0, psr_15 = 0, mem_ack = 0;
  logic [15:0] mdr_out, mem_addr, mem_wdata;
  logic        ready, acv, bus_err, mem_req, mem_we;
`ifdef LC3_MMIO_EN
  logic        kb_valid = 0, disp_ready = 1, disp_valid;
  logic [7:0]  kb_data = '0, disp_data;
`endif

  typedef struct packed { logic [15:0] mdr; logic err; } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0;

  lc3_mem_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .psr_15(psr_15), .mdr_out(mdr_out), .ready(ready),
    .acv(acv), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef LC3_MMIO_EN
    .kb_valid(kb_valid), .kb_data(kb_data), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_data(disp_data),
`endif
    .mem_ack(mem_ack));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1; tick(); ld_mar = 0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; ld_mdr = 1; tick(); ld_mdr = 0;
  endtask

  // Monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 16'(ready), 16'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_mdr", mdr_out, e.mdr);
        check("sb_bus_err", 16'(bus_err), 16'(e.err));
      end
    end
  end

  initial begin
    tick(2);
    rst = 0;
    check("rst_ready", 16'(ready), 16'h0);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_mdr", mdr_out, 16'h0);
    check("rst_acv", 16'(acv), 16'h0);
    check("rst_bus_err", 16'(bus_err), 16'h0);

    // T1: write x1234 to x3000, ack in third request cycle.
    load_mar(16'h3000);
    load_mdr(16'h1234);
    r_w = 1; mio_en = 1; exp_q.push_back('{16'h1234, 1'b0});
    tick();
    check("t1_mem_req", 16'(mem_req), 16'h1);
    check("t1_mem_we", 16'(mem_we), 16'h1);
    check("t1_addr", mem_addr, 16'h3000);
    check("t1_wdata", mem_wdata, 16'h1234);
    tick(2);
    check("t1_wait_ready", 16'(ready), 16'h0);
    mem_ack = 1; tick(); mem_ack = 0;
    check("t1_ready", 16'(ready), 16'h1);
    check("t1_req_drop", 16'(mem_req), 16'h0);
    tick();
    check("t1_ready_pulse", 16'(ready), 16'h0);
    tick(3);  // mio_en still high: must not start another access
    check("t1_no_retrigger", 16'(mem_req), 16'h0);

    // T2: read x4000 with immediate ack -> ready two edges after start.
    mio_en = 0; r_w = 0; tick();
    load_mar(16'h4000);
    mio_en = 1; mem_ack = 1; mem_rdata = 16'hBEEF; exp_q.push_back('{16'hBEEF, 1'b0});
    tick();
    check("t2_ready_early", 16'(ready), 16'h0);
    tick(); mem_ack = 0;
    check("t2_ready", 16'(ready), 16'h1);
    check("t2_mdr", mdr_out, 16'hBEEF);
    tick();

    // T3: user-mode access below x3000 is blocked.
    mio_en = 0; psr_15 = 1;
    load_mar(16'h2FFF);
    check("t3_acv_set", 16'(acv), 16'h1);
    mio_en = 1; tick();
    check("t3_no_req", 16'(mem_req), 16'h0);
    tick(2);
    check("t3_no_req_later", 16'(mem_req), 16'h0);
    load_mar(16'h3000);
    check("t3_acv_clr", 16'(acv), 16'h0);
    load_mar(16'hFE00);
    check("t3_acv_io", 16'(acv), 16'h1);
    mio_en = 0; psr_15 = 0;
    load_mar(16'h5000);
    check("t3_acv_super", 16'(acv), 16'h0);

    // T4: no ack, timeout of 4 -> ready+bus_err five edges after start, MDR cleared.
    mio_en = 1; exp_q.push_back('{16'h0000, 1'b1});
    tick(4);
    check("t4_not_yet", 16'(ready), 16'h0);
    tick();
    check("t4_ready", 16'(ready), 16'h1);
    check("t4_bus_err", 16'(bus_err), 16'h1);
    tick();
    check("t4_err_pulse", 16'(bus_err), 16'h0);

    // T5: reset during request.
    mio_en = 0; tick();
    load_mdr(16'h7777);
    load_mar(16'h6000);
    mio_en = 1; tick();
    check("t5_req", 16'(mem_req), 16'h1);
    rst = 1; mio_en = 0; tick(); rst = 0;
    check("t5_req_drop", 16'(mem_req), 16'h0);
    check("t5_mdr_rst", mdr_out, 16'h0);
    mem_ack = 1; tick(2); mem_ack = 0;  // stray ack in IDLE is ignored
    check("t5_idle_ack", 16'(ready), 16'h0);

`ifdef LC3_MMIO_EN
    // T6: keyboard read then display write, both internal.
    kb_data = 8'h41; kb_valid = 1; tick(); kb_valid = 0;
    load_mar(16'hFE02);
    r_w = 0; mio_en = 1; exp_q.push_back('{16'h0041, 1'b0});
    tick();
    check("t6_no_req", 16'(mem_req), 16'h0);
    check("t6_ready", 16'(ready), 16'h1);
    mio_en = 0; tick();
    load_mar(16'hFE00);
    mio_en = 1; exp_q.push_back('{16'h0000, 1'b0});
    tick(); mio_en = 0; tick();
    load_mdr(16'h0042);
    load_mar(16'hFE06);
    r_w = 1; mio_en = 1; exp_q.push_back('{16'h0042, 1'b0});
    tick();
    check("t6_disp_valid", 16'(disp_valid), 16'h1);
    check("t6_disp_data", 16'(disp_data), 16'h0042);
    tick();
    check("t6_disp_pulse", 16'(disp_valid), 16'h0);
    mio_en = 0; tick();
`endif

    tick(2);
    check("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
